spiflash_responder: RTL and testbench

//  Synthesizable single-bit SPI flash responder that serves the flash read

---
 rtl/spiflash_responder.sv | 188 ++++++++++++++++++
 tb/tb_spiflash_responder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spiflash_responder.sv
// SPI mode-0 flash read responder: oversamples the SPI pins in the core_clk domain
// and streams bytes fetched through a one-deep prefetch buffer on a req/ack port.
module spiflash_responder #(
   parameter int         ADDR_W   = 24,
   parameter logic [7:0] CMD_READ = 8'h03,
   parameter logic [7:0] CMD_WAKE = 8'hAB,
   parameter logic [7:0] CMD_RST  = 8'hFF
) (
   input  logic              core_clk,
   input  logic              core_rstn,
   input  logic              flash_csb,
   input  logic              flash_clk,
   input  logic              flash_io0,
   output logic              flash_io1,
   output logic              flash_io1_oeb,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ack,
   output logic              busy,
   output logic              cmd_err,
   output logic              underrun
);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

   state_t            state, state_nxt;
   logic [1:0]        csb_q, clk_q, io0_q;
   logic              clk_d;
   logic              csb_s, clk_s, io0_s, rise, fall;
   logic [4:0]        bit_cnt;
   logic [22:0]       sh_in;
   logic [7:0]        sh_out;
   logic [2:0]        out_cnt;
   logic [ADDR_W-1:0] byte_addr, start_addr, want_addr;
   logic [7:0]        buf_q, avail_data, cmd_byte;
   logic [23:0]       addr_full;
   logic              buf_vld, need_fetch, drop, avail, want;
   logic              bad_cmd, addr_done, load;

   // 2-FF synchronisers; csb resets high so busy starts low
   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         csb_q <= 2'b11;
         clk_q <= 2'b00;
         io0_q <= 2'b00;
         clk_d <= 1'b0;
      end else begin
         csb_q <= {csb_q[0], flash_csb};
         clk_q <= {clk_q[0], flash_clk};
         io0_q <= {io0_q[0], flash_io0};
         clk_d <= clk_q[1];
      end
   end

   assign csb_s      = csb_q[1];
   assign clk_s      = clk_q[1];
   assign io0_s      = io0_q[1];
   assign rise       = clk_s & ~clk_d;
   assign fall       = ~clk_s & clk_d;
   assign cmd_byte   = {sh_in[6:0], io0_s};
   assign addr_full  = {sh_in, io0_s};
   assign start_addr = addr_full[ADDR_W-1:0];

   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) state <= IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      bad_cmd   = 1'b0;
      addr_done = 1'b0;
      load      = 1'b0;
      case (state)
         IDLE: if (!csb_s) state_nxt = CMD;
         CMD: begin
            if (rise && bit_cnt == 5'd7) begin
               if (cmd_byte == CMD_READ) begin
                  state_nxt = ADDR;
               end else begin
                  state_nxt = IGNORE;
                  bad_cmd   = (cmd_byte != CMD_WAKE) && (cmd_byte != CMD_RST);
               end
            end
         end
         ADDR: begin
            if (rise && bit_cnt == 5'd23) begin
               state_nxt = DATA;
               addr_done = 1'b1;
            end
         end
         DATA:    load = fall && (out_cnt == 3'd0);
         default: ;
      endcase
      if (csb_s) begin
         state_nxt = IDLE;
         bad_cmd   = 1'b0;
         addr_done = 1'b0;
         load      = 1'b0;
      end
   end

   assign flash_io1_oeb = (state != DATA);
   assign flash_io1     = (state == DATA) & sh_out[7];
   assign busy          = ~csb_s;

   // An ack landing on the same cycle as the byte boundary still meets the deadline
   assign avail      = buf_vld | (mem_rd & mem_ack & ~drop);
   assign avail_data = buf_vld ? buf_q : mem_rdata;
   assign want       = addr_done | load | need_fetch;
   assign want_addr  = addr_done ? start_addr :
                       load      ? byte_addr + ADDR_W'(1) : byte_addr;

   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         bit_cnt    <= '0;
         sh_in      <= '0;
         sh_out     <= '0;
         out_cnt    <= '0;
         byte_addr  <= '0;
         buf_q      <= '0;
         buf_vld    <= 1'b0;
         need_fetch <= 1'b0;
         drop       <= 1'b0;
         mem_rd     <= 1'b0;
         mem_addr   <= '0;
         cmd_err    <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         cmd_err  <= bad_cmd;
         underrun <= 1'b0;

         if (state_nxt != state)                     bit_cnt <= '0;
         else if (rise && (state == CMD || state == ADDR)) bit_cnt <= bit_cnt + 5'd1;
         if (rise && (state == CMD || state == ADDR)) sh_in <= {sh_in[21:0], io0_s};

         if (mem_rd && mem_ack) begin
            mem_rd <= 1'b0;
            drop   <= 1'b0;
            if (!drop) begin
               buf_q   <= mem_rdata;
               buf_vld <= 1'b1;
            end
         end

         if (state == DATA && fall && !csb_s) begin
            out_cnt <= out_cnt + 3'd1;
            if (!load) sh_out <= {sh_out[6:0], 1'b0};
         end

         // Byte boundary: a missed deadline sends FF, skips that address and
         // discards the in-flight read when it eventually returns
         if (load) begin
            sh_out    <= avail ? avail_data : 8'hFF;
            buf_vld   <= 1'b0;
            byte_addr <= byte_addr + ADDR_W'(1);
            if (!avail) begin
               underrun <= 1'b1;
               if (mem_rd && !mem_ack) drop <= 1'b1;
            end
         end

         if (addr_done) begin
            byte_addr <= start_addr;
            out_cnt   <= '0;
            buf_vld   <= 1'b0;
         end

         if (want) begin
            if (!mem_rd) begin
               mem_rd     <= 1'b1;
               mem_addr   <= want_addr;
               need_fetch <= 1'b0;
            end else begin
               need_fetch <= 1'b1;
            end
         end

         if (state == IDLE) begin
            buf_vld    <= 1'b0;
            need_fetch <= 1'b0;
            if (mem_rd && !mem_ack) drop <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spiflash_responder.sv
// Bench for spiflash_responder: 24-bit and 8-bit address instances share the SPI pins,
// each with its own memory model; MISO bytes are checked against computed memory contents.
module tb_spiflash_responder;

   logic core_clk = 1'b0;
   logic core_rstn = 1'b0;
   logic flash_csb = 1'b1, flash_clk = 1'b0, flash_io0 = 1'b0;

   logic        io1_a, oeb_a, mem_rd_a, mem_ack_a, busy_a, cmd_err_a, underrun_a;
   logic [23:0] mem_addr_a;
   logic [7:0]  mem_rdata_a;
   logic        io1_b, oeb_b, mem_rd_b, mem_ack_b, busy_b, cmd_err_b, underrun_b;
   logic [7:0]  mem_addr_b, mem_rdata_b;

   int n_checks = 0, n_pass = 0;
   int n_cmd_err = 0, n_underrun = 0, n_oeb_low = 0;
   int req_a_cnt = 0, slow_idx = -1, slow_lat = 70, lat_a, lat_b;
   logic [23:0] log_a[$];
   logic [7:0]  log_b[$];
   logic [7:0]  rx_a[$], rx_b[$];

   spiflash_responder #(.ADDR_W(24)) u_dut (
      .core_clk(core_clk), .core_rstn(core_rstn), .flash_csb(flash_csb), .flash_clk(flash_clk),
      .flash_io0(flash_io0), .flash_io1(io1_a), .flash_io1_oeb(oeb_a), .mem_rd(mem_rd_a),
      .mem_addr(mem_addr_a), .mem_rdata(mem_rdata_a), .mem_ack(mem_ack_a), .busy(busy_a),
      .cmd_err(cmd_err_a), .underrun(underrun_a));

   spiflash_responder #(.ADDR_W(8)) u_wrap (
      .core_clk(core_clk), .core_rstn(core_rstn), .flash_csb(flash_csb), .flash_clk(flash_clk),
      .flash_io0(flash_io0), .flash_io1(io1_b), .flash_io1_oeb(oeb_b), .mem_rd(mem_rd_b),
      .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b), .mem_ack(mem_ack_b), .busy(busy_b),
      .cmd_err(cmd_err_b), .underrun(underrun_b));

   always #5 core_clk = ~core_clk;

   function automatic logic [7:0] mem_a(input logic [23:0] a);
      case (a)
         24'h000100: return 8'hDE;
         24'h000101: return 8'hAD;
         24'h000102: return 8'hBE;
         24'h000103: return 8'hEF;
         default:    return (a[7:0] * 8'd13) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
      endcase
   endfunction

   function automatic logic [7:0] mem_b(input logic [7:0] a);
      return {a[3:0], a[7:4]} ^ 8'hC3;
   endfunction

   // memory models: acknowledge after a random latency, log every request address
   initial begin
      mem_ack_a = 1'b0; mem_rdata_a = '0;
      forever begin
         @(negedge core_clk);
         mem_ack_a = 1'b0;
         if (mem_rd_a === 1'b1) begin
            lat_a = (req_a_cnt == slow_idx) ? slow_lat : int'($urandom_range(1, 3));
            log_a.push_back(mem_addr_a);
            req_a_cnt++;
            repeat (lat_a - 1) @(negedge core_clk);
            mem_rdata_a = mem_a(mem_addr_a);
            mem_ack_a   = 1'b1;
         end
      end
   end

   initial begin
      mem_ack_b = 1'b0; mem_rdata_b = '0;
      forever begin
         @(negedge core_clk);
         mem_ack_b = 1'b0;
         if (mem_rd_b === 1'b1) begin
            lat_b = int'($urandom_range(1, 3));
            log_b.push_back(mem_addr_b);
            repeat (lat_b - 1) @(negedge core_clk);
            mem_rdata_b = mem_b(mem_addr_b);
            mem_ack_b   = 1'b1;
         end
      end
   end

   always @(negedge core_clk) begin
      if (cmd_err_a === 1'b1)  n_cmd_err++;
      if (underrun_a === 1'b1) n_underrun++;
      if (oeb_a === 1'b0)      n_oeb_low++;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   // one SPI period of 8 core_clk cycles; MISO sampled just before the rising edge
   task automatic spi_bit(input logic mosi, output logic so_a, output logic so_b);
      flash_clk = 1'b0;
      flash_io0 = mosi;
      repeat (4) @(negedge core_clk);
      so_a = io1_a;
      so_b = io1_b;
      flash_clk = 1'b1;
      repeat (4) @(negedge core_clk);
   endtask

   task automatic spi_txn(input logic [7:0] cmd, input logic [23:0] addr, input int nbits);
      logic [31:0] hdr;
      logic a, b;
      logic [7:0] sa, sb;
      rx_a.delete(); rx_b.delete();
      hdr = {cmd, addr};
      sa = '0; sb = '0;
      flash_csb = 1'b0;
      repeat (4) @(negedge core_clk);
      for (int i = 31; i >= 0; i--) spi_bit(hdr[i], a, b);
      for (int i = 0; i < nbits; i++) begin
         spi_bit(1'b0, a, b);
         sa = {sa[6:0], a};
         sb = {sb[6:0], b};
         if (i % 8 == 7) begin
            rx_a.push_back(sa);
            rx_b.push_back(sb);
         end
      end
   endtask

   task automatic spi_end();
      flash_csb = 1'b1;
      repeat (4) @(negedge core_clk);
      flash_clk = 1'b0;
      repeat (8) @(negedge core_clk);
   endtask

   task automatic test_reset();
      logic rd_seen;
      rd_seen = 1'b0;
      core_rstn = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge core_clk);
         flash_csb = 1'($urandom_range(0, 1));
         flash_clk = 1'($urandom_range(0, 1));
         flash_io0 = 1'($urandom_range(0, 1));
         if (mem_rd_a !== 1'b0 || mem_rd_b !== 1'b0) rd_seen = 1'b1;
      end
      n_checks++; if (rd_seen !== 1'b0) $display("FAIL reset_mem_rd: got %b want 0", rd_seen); else n_pass++;
      n_checks++; if (io1_a !== 1'b0) $display("FAIL reset_io1: got %b want 0", io1_a); else n_pass++;
      n_checks++; if (oeb_a !== 1'b1) $display("FAIL reset_oeb: got %b want 1", oeb_a); else n_pass++;
      n_checks++; if (mem_addr_a !== 24'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr_a); else n_pass++;
      n_checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else n_pass++;
      n_checks++; if (cmd_err_a !== 1'b0) $display("FAIL reset_cmd_err: got %b want 0", cmd_err_a); else n_pass++;
      n_checks++; if (underrun_a !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun_a); else n_pass++;
      flash_csb = 1'b1; flash_clk = 1'b0; flash_io0 = 1'b0;
      repeat (2) @(negedge core_clk);
      core_rstn = 1'b1;
      repeat (4) @(negedge core_clk);
   endtask

   task automatic test_read();
      int base, nreq;
      logic [31:0] exp_word;
      base = log_a.size();
      exp_word = 32'hDEADBEEF;
      spi_txn(8'h03, 24'h000100, 32);
      spi_end();
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (rx_a.size() <= k || rx_a[k] !== exp_word[31-8*k -: 8])
            $display("FAIL read_byte%0d: got %h want %h", k, (rx_a.size() > k) ? rx_a[k] : 8'hxx, exp_word[31-8*k -: 8]);
         else n_pass++;
      end
      nreq = log_a.size() - base;
      n_checks++; if (nreq !== 5) $display("FAIL read_req_count: got %0d want 5", nreq); else n_pass++;
      for (int k = 0; k < 5 && k < nreq; k++) begin
         n_checks++;
         if (log_a[base+k] !== 24'h000100 + 24'(k))
            $display("FAIL read_mem_addr%0d: got %h want %h", k, log_a[base+k], 24'h000100 + 24'(k));
         else n_pass++;
      end
   endtask

   task automatic test_wrap();
      int base;
      base = log_b.size();
      spi_txn(8'h03, 24'h0000FF, 16);
      spi_end();
      n_checks++; if (rx_b[0] !== mem_b(8'hFF)) $display("FAIL wrap_b0: got %h want %h", rx_b[0], mem_b(8'hFF)); else n_pass++;
      n_checks++; if (rx_b[1] !== mem_b(8'h00)) $display("FAIL wrap_b1: got %h want %h", rx_b[1], mem_b(8'h00)); else n_pass++;
      n_checks++;
      if (log_b.size() < base + 2 || log_b[base+1] !== 8'h00)
         $display("FAIL wrap_mem_addr: got %h want 00", (log_b.size() >= base + 2) ? log_b[base+1] : 8'hxx);
      else n_pass++;
      n_checks++; if (rx_a[1] !== 8'hDE) $display("FAIL wide_no_wrap: got %h want de", rx_a[1]); else n_pass++;
   endtask

   task automatic test_bad_opcode();
      int e0, o0, r0;
      e0 = n_cmd_err; o0 = n_oeb_low; r0 = log_a.size();
      spi_txn(8'h0B, 24'h000100, 16);
      spi_end();
      n_checks++; if (n_cmd_err - e0 !== 1) $display("FAIL bad_cmd_err: got %0d pulses want 1", n_cmd_err - e0); else n_pass++;
      n_checks++; if (n_oeb_low - o0 !== 0) $display("FAIL bad_oeb: got %0d low cycles want 0", n_oeb_low - o0); else n_pass++;
      n_checks++; if (log_a.size() - r0 !== 0) $display("FAIL bad_mem_rd: got %0d reqs want 0", log_a.size() - r0); else n_pass++;
   endtask

   task automatic test_underrun();
      logic [23:0] ad;
      logic [7:0] exp [3];
      int u0;
      ad = 24'($urandom_range(0, 24'hFFFFF0));
      exp[0] = mem_a(ad); exp[1] = 8'hFF; exp[2] = mem_a(ad + 24'd2);
      u0 = n_underrun;
      slow_idx = req_a_cnt + 1;
      spi_txn(8'h03, ad, 24);
      spi_end();
      slow_idx = -1;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (rx_a[k] !== exp[k]) $display("FAIL underrun_byte%0d: got %h want %h", k, rx_a[k], exp[k]);
         else n_pass++;
      end
      n_checks++; if (n_underrun - u0 !== 1) $display("FAIL underrun_pulse: got %0d want 1", n_underrun - u0); else n_pass++;
   endtask

   task automatic test_abort();
      spi_txn(8'h03, 24'h000100, 12);
      flash_csb = 1'b1;
      repeat (4) @(negedge core_clk);
      n_checks++; if (oeb_a !== 1'b1) $display("FAIL abort_oeb: got %b want 1", oeb_a); else n_pass++;
      n_checks++; if (busy_a !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy_a); else n_pass++;
      n_checks++; if (rx_a[0] !== 8'hDE) $display("FAIL abort_first_byte: got %h want de", rx_a[0]); else n_pass++;
      flash_clk = 1'b0;
      repeat (8) @(negedge core_clk);
      spi_txn(8'h03, 24'h000102, 16);
      spi_end();
      n_checks++; if (rx_a[0] !== 8'hBE) $display("FAIL abort_reread0: got %h want be", rx_a[0]); else n_pass++;
      n_checks++; if (rx_a[1] !== 8'hEF) $display("FAIL abort_reread1: got %h want ef", rx_a[1]); else n_pass++;
   endtask

   task automatic test_random();
      logic [23:0] ad;
      logic [7:0] eb;
      int nb, op, o0, r0, e0, u0;
      for (int t = 0; t < 6; t++) begin
         op = int'($urandom_range(0, 3));
         ad = 24'($urandom);
         nb = int'($urandom_range(1, 4));
         o0 = n_oeb_low; r0 = log_a.size(); e0 = n_cmd_err; u0 = n_underrun;
         if (op == 0) begin
            spi_txn((t % 2 == 0) ? 8'hAB : 8'hFF, ad, 16);
            spi_end();
            n_checks++; if (n_oeb_low - o0 !== 0) $display("FAIL rand_ign_oeb: got %0d want 0", n_oeb_low - o0); else n_pass++;
            n_checks++; if (log_a.size() - r0 !== 0) $display("FAIL rand_ign_rd: got %0d want 0", log_a.size() - r0); else n_pass++;
            n_checks++; if (n_cmd_err - e0 !== 0) $display("FAIL rand_ign_err: got %0d want 0", n_cmd_err - e0); else n_pass++;
         end else begin
            spi_txn(8'h03, ad, 8 * nb);
            spi_end();
            for (int k = 0; k < nb; k++) begin
               n_checks++;
               if (rx_a[k] !== mem_a(ad + 24'(k)))
                  $display("FAIL rand_a @%h+%0d: got %h want %h", ad, k, rx_a[k], mem_a(ad + 24'(k)));
               else n_pass++;
               eb = mem_b(ad[7:0] + 8'(k));
               n_checks++;
               if (rx_b[k] !== eb) $display("FAIL rand_b @%h+%0d: got %h want %h", ad[7:0], k, rx_b[k], eb);
               else n_pass++;
            end
            n_checks++; if (n_underrun - u0 !== 0) $display("FAIL rand_underrun: got %0d want 0", n_underrun - u0); else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_wrap();
      test_bad_opcode();
      test_underrun();
      test_abort();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
